// File: rtl/regfile_loader.sv
// regfile_loader: byte-stream initiator that fills register file entries 0..NUM_WORDS-1.
// Latency: 3 cycles per word at full throughput (LOW, HIGH, WRITE), then 1 FIN cycle.
// Backpressure: in_ready is high only in LOW/HIGH (and CHECK); the loader waits forever for bytes.
// Optional checksum byte after the last word: define REGFILE_LOADER_CHECKSUM_EN.
`timescale 1ns/1ps

module regfile_loader #(
  parameter int NUM_WORDS = 4,
  parameter int ADDR_W    = 2,
  parameter int DATA_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              in_ready,
  output logic [ADDR_W-1:0] w_add,
  output logic              w_flag,
  output logic [DATA_W-1:0] w_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   word_cnt,
  output logic              err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOW   = 3'd1,
    HIGH  = 3'd2,
    WRITE = 3'd3,
`ifdef REGFILE_LOADER_CHECKSUM_EN
    CHECK = 3'd4,
`endif
    FIN   = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0] ADD_ONE = 1;
  localparam logic [ADDR_W:0]   CNT_ONE = 1;
  localparam logic [ADDR_W:0]   CNT_END = (ADDR_W+1)'(NUM_WORDS);

  state_t              state_q;
  logic [7:0]          lo_q;
  logic                in_ready_q;
  logic [ADDR_W-1:0]   w_add_q;
  logic                w_flag_q;
  logic [DATA_W-1:0]   w_data_q;
  logic                busy_q;
  logic                done_q;
  logic [ADDR_W:0]     word_cnt_q;
  logic [ADDR_W:0]     word_cnt_d;
  logic                last_d;
  logic                hs;
`ifdef REGFILE_LOADER_CHECKSUM_EN
  logic [7:0]          csum_q;
  logic                err_q;
`endif

  // Handshake qualifier and end-of-sequence decision for the WRITE exit.
  always_comb begin
    hs         = in_valid && in_ready_q;
    word_cnt_d = word_cnt_q + CNT_ONE;
    last_d     = (word_cnt_d >= CNT_END);
  end

  // Sequencer: every output is registered so the register file sees stable values all cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      lo_q       <= '0;
      in_ready_q <= 1'b0;
      w_add_q    <= '0;
      w_flag_q   <= 1'b0;
      w_data_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      word_cnt_q <= '0;
`ifdef REGFILE_LOADER_CHECKSUM_EN
      csum_q     <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      // Single-cycle strobes drop unless a transition below raises them.
      w_flag_q <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= LOW;
            word_cnt_q <= '0;
            w_add_q    <= '0;
            busy_q     <= 1'b1;
            in_ready_q <= 1'b1;
`ifdef REGFILE_LOADER_CHECKSUM_EN
            csum_q     <= '0;
            err_q      <= 1'b0;
`endif
          end
        end
        LOW: begin
          if (hs) begin
            lo_q    <= in_byte;
            state_q <= HIGH;
`ifdef REGFILE_LOADER_CHECKSUM_EN
            csum_q  <= csum_q ^ in_byte;
`endif
          end
        end
        HIGH: begin
          if (hs) begin
            w_data_q   <= {in_byte, lo_q};
            w_flag_q   <= 1'b1;
            in_ready_q <= 1'b0;
            state_q    <= WRITE;
`ifdef REGFILE_LOADER_CHECKSUM_EN
            csum_q     <= csum_q ^ in_byte;
`endif
          end
        end
        WRITE: begin
          word_cnt_q <= word_cnt_d;
          if (!last_d) begin
            w_add_q    <= w_add_q + ADD_ONE;
            in_ready_q <= 1'b1;
            state_q    <= LOW;
          end else begin
`ifdef REGFILE_LOADER_CHECKSUM_EN
            in_ready_q <= 1'b1;
            state_q    <= CHECK;
`else
            done_q     <= 1'b1;
            state_q    <= FIN;
`endif
          end
        end
`ifdef REGFILE_LOADER_CHECKSUM_EN
        CHECK: begin
          // Writes are already committed; a bad checksum only raises err.
          if (hs) begin
            err_q      <= (in_byte != csum_q);
            in_ready_q <= 1'b0;
            done_q     <= 1'b1;
            state_q    <= FIN;
          end
        end
`endif
        FIN: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q    <= IDLE;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready = in_ready_q;
  assign w_add    = w_add_q;
  assign w_flag   = w_flag_q;
  assign w_data   = w_data_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign word_cnt = word_cnt_q;
`ifdef REGFILE_LOADER_CHECKSUM_EN
  assign err      = err_q;
`else
  assign err      = 1'b0;
`endif

endmodule

// File: doc/regfile_loader.md
Name: regfile_loader

Overview:
- Write-side initiator for the 4-entry x 16-bit data register file.
- Accepts a byte stream over a valid/ready handshake and assembles little-endian 16-bit words.
- Drives the register file write port (w_add, w_flag, w_data) to fill entries 0..NUM_WORDS-1 in order.
- Sits between the external load/debug byte source and the register file. Used for power-up and test preload.

Parameters:
- NUM_WORDS, 4, number of words loaded per start; range 1..2^ADDR_W.
- ADDR_W, 2, width of the write address.
- DATA_W, 16, word width; fixed at 2 bytes.

Ports:
- clk  in  1  clock; all logic on the posedge.
- reset  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle request to begin a load sequence.
- in_valid  in  1  byte source has a valid byte.
- in_byte  in  8  byte data.
- in_ready  out  1  loader accepts in_byte this cycle.
- w_add  out  ADDR_W  register file write address.
- w_flag  out  1  register file write enable.
- w_data  out  DATA_W  register file write data.
- busy  out  1  a sequence is in progress.
- done  out  1  one-cycle pulse when the sequence completes.
- word_cnt  out  ADDR_W+1  number of words written in the current or last sequence.
- err  out  1  checksum mismatch flag (optional feature only).

Behaviour:
- Reset: state=IDLE. in_ready, w_flag, busy, done, err = 0. w_add, w_data, word_cnt = 0. Byte latch cleared.
- States: IDLE, LOW, HIGH, WRITE, CHECK (feature only), FIN.
- IDLE, start=1: go to LOW. Clear word_cnt, w_add and err. busy=1 from the next cycle.
- IDLE, start=0: no change.
- start while not IDLE: ignored.
- LOW: in_ready=1. On in_valid&&in_ready, latch in_byte as data[7:0] and go to HIGH.
- HIGH: in_ready=1. On handshake, in_byte becomes data[15:8] and the state goes to WRITE.
- LOW/HIGH with no in_valid: hold state indefinitely. No timeout.
- Handshake rule: a byte transfers only on a posedge with in_valid=1 and in_ready=1. A source may hold in_valid high across cycles.
- WRITE lasts exactly one cycle:
  - w_flag=1, w_data=assembled word, w_add=current index, in_ready=0.
  - All three are registered and stable for the full cycle, so the register file's negedge sample is clean.
- Leaving WRITE:
  - word_cnt increments.
  - If word_cnt+1 < NUM_WORDS: w_add increments and the state returns to LOW.
  - Otherwise: go to FIN, or CHECK if the feature is enabled.
- w_flag is 0 in every state except WRITE. w_data and w_add hold their last values outside WRITE.
- FIN lasts one cycle: done=1, busy=0 from the next cycle, then IDLE.
- Latency: at full throughput (in_valid always 1), each word takes 3 cycles. A 4-word sequence runs 12 cycles from the first LOW cycle to the last WRITE, plus 1 FIN cycle.
- w_add wraps at 2^ADDR_W, which is unreachable when NUM_WORDS <= 2^ADDR_W.
- Reset mid-sequence: the partial word is discarded with no write, the state returns to IDLE and all outputs go to their reset values.
- Reset and start asserted together: reset wins.

Optional Feature:
- Macro: REGFILE_LOADER_CHECKSUM_EN.
- Defined:
  - After the last WRITE, the state is CHECK with in_ready=1.
  - One trailing byte is accepted and compared with the XOR of all 2*NUM_WORDS data bytes.
  - On mismatch, err=1. err holds until the next accepted start or reset. Then FIN.
  - Writes are already committed and are not rolled back.
- Not defined: no CHECK state, no trailing byte, and err is tied to 0.

Test Plan:
- Reset, then start. Bytes 34,12,78,56,BC,9A,F0,DE sent with in_valid held high -> write pulses with (add 0, 1234), (1, 5678), (2, 9ABC), (3, DEF0), each w_flag exactly one cycle. done pulses in the 13th cycle after LOW entry. word_cnt=4.
- Same stream with in_valid toggling 1/0 each cycle -> identical writes. in_ready never accepts while in_valid=0. No extra w_flag pulses.
- Reset asserted after 3 bytes accepted -> no write for the partial word 1. busy=0, w_flag=0. A fresh start then rewrites from address 0.
- start pulsed during HIGH -> ignored. Sequence completes normally with exactly 4 writes.
- Checksum enabled, trailing byte = XOR of all 8 bytes (0x00 for the stream above) -> err=0. Trailing byte 0x01 -> err=1, done still pulses, err cleared on the next start.
